// File: rtl/hilo_pkg.sv
// hilo_pkg
// Shared definitions for the EX-stage Hi/Lo multiply/divide sequencer:
// operation encodings as seen on cHiLoOp, FSM state encodings, datapath
// step mode, iteration count and small op-classification helpers.
package hilo_pkg;

    typedef enum logic [2:0] {
        HILO_NONE  = 3'b000,
        HILO_MULT  = 3'b001,
        HILO_MULTU = 3'b010,
        HILO_MADD  = 3'b011,
        HILO_MSUB  = 3'b100,
        HILO_DIV   = 3'b101,
        HILO_DIVU  = 3'b110,
        HILO_RSVD  = 3'b111
    } hiloOp_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } hiloState_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } iterMode_t;

    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = 5;

    // Codes 001..110 start an operation; 000 and 111 are no-ops.
    function automatic logic isValidOp(input hiloOp_t op);
        return (op != HILO_NONE) && (op != HILO_RSVD);
    endfunction

    function automatic logic isDivOp(input hiloOp_t op);
        return (op == HILO_DIV) || (op == HILO_DIVU);
    endfunction

    // Operations whose operands are two's-complement.
    function automatic logic isSignedOp(input hiloOp_t op);
        return (op == HILO_MULT) || (op == HILO_MADD) ||
               (op == HILO_MSUB) || (op == HILO_DIV);
    endfunction

endpackage

// File: rtl/hilo_iter_core.sv
// hilo_iter_core
// Per-step unsigned datapath shared by multiply and divide. The 2*WIDTH
// accumulator holds {upper, lower}; the lower half is preloaded with the
// multiplier (multiply) or dividend (divide), and a second register holds the
// multiplicand or divisor. Each step performs one shift-add or one restoring
// shift-subtract. After WIDTH steps acc = product, or {remainder, quotient}.
//
// Ports:
//   Clk          in   clock, rising edge
//   Reset        in   asynchronous active-low reset
//   load         in   load loadLo into acc lower half (upper cleared), latch loadOperand
//   step         in   perform one iteration step this cycle
//   mode         in   MODE_MUL shift-add, MODE_DIV restoring shift-subtract
//   loadLo       in   multiplier magnitude / dividend magnitude
//   loadOperand  in   multiplicand magnitude / divisor magnitude
//   acc          out  accumulator / {remainder, quotient}
module hilo_iter_core
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               load,
    input  logic               step,
    input  iterMode_t          mode,
    input  logic [WIDTH-1:0]   loadLo,
    input  logic [WIDTH-1:0]   loadOperand,
    output logic [2*WIDTH-1:0] acc
);

    logic [WIDTH-1:0]   operand;
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext;
    logic [WIDTH:0]     divPartial;
    logic [WIDTH:0]     divDiff;
    logic               divFits;
    logic [2*WIDTH-1:0] divNext;

    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier LSB is set, then shift the whole thing right keeping
        // the carry as the new MSB.
        mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                  (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        mulNext = {mulSum, acc[WIDTH-1:1]};

        // Divide: shift the next dividend bit into the partial remainder.
        // The partial needs WIDTH+1 bits because the remainder can be up to
        // divisor-1 before doubling. When the subtract is not taken the
        // partial is below the divisor and therefore fits in WIDTH bits.
        divPartial = acc[2*WIDTH-1:WIDTH-1];
        divDiff    = divPartial - {1'b0, operand};
        divFits    = (divPartial >= {1'b0, operand});
        divNext    = divFits ? {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                             : {divPartial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            acc     <= '0;
            operand <= '0;
        end else if (load) begin
            acc     <= {{WIDTH{1'b0}}, loadLo};
            operand <= loadOperand;
        end else if (step) begin
            acc <= (mode == MODE_MUL) ? mulNext : divNext;
        end
    end

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// hilo_muldiv_sequencer
// Multi-cycle controller for the EX-stage Hi/Lo unit. Accepts a Hi/Lo op
// from ID/EX, stalls the front pipeline while a 32-step iterative multiply
// or divide runs, applies sign/accumulate fix-up, then emits one HiLoWrite
// strobe with the 64-bit {Hi,Lo} result.
//
// Valid/ready: an op is taken in the single IDLE cycle where OpValid=1,
// cHiLoOp is 001..110 and Flush=0; Stall rises combinationally in that same
// cycle and stays high until the DONE cycle, in which HiLoWrite pulses for
// exactly one cycle and Stall drops so the held instruction advances. Inputs
// are not sampled again until the FSM is back in IDLE.
//
// Ports:
//   Clk         in   pipeline clock, rising edge
//   Reset       in   asynchronous active-low reset
//   OpValid     in   ID/EX holds a valid instruction
//   cHiLoOp     in   Hi/Lo operation code (see hiloOp_t)
//   OperandA    in   rs value (multiplicand / dividend)
//   OperandB    in   rt value (multiplier / divisor)
//   Hi, Lo      in   current Hi/Lo registers (accumulate base for MADD/MSUB)
//   Flush       in   abort any operation in progress, block acceptance
//   Stall       out  freeze PC, IF/ID and ID/EX
//   Busy        out  FSM not in IDLE
//   HiLoWrite   out  one-cycle {Hi,Lo} write strobe
//   HiLoResult  out  {Hi,Lo} result, non-zero only while HiLoWrite=1
//   DbgState    out  current FSM state, for observation only
//
// Only WIDTH=32 is supported.
module hilo_muldiv_sequencer
    import hilo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               OpValid,
    input  logic [2:0]         cHiLoOp,
    input  logic [WIDTH-1:0]   OperandA,
    input  logic [WIDTH-1:0]   OperandB,
    input  logic [WIDTH-1:0]   Hi,
    input  logic [WIDTH-1:0]   Lo,
    input  logic               Flush,
    output logic               Stall,
    output logic               Busy,
    output logic               HiLoWrite,
    output logic [2*WIDTH-1:0] HiLoResult,
    output hiloState_t         DbgState
);

    hiloState_t         state;
    hiloState_t         nextState;
    logic [CNT_W-1:0]   count;
    hiloOp_t            opReg;
    logic               signA;
    logic               signB;
    logic               divZero;
    logic [2*WIDTH-1:0] hiLoCap;
    logic [WIDTH-1:0]   origA;
    logic [2*WIDTH-1:0] resultReg;

    hiloOp_t            opIn;
    logic               accept;
    logic               inSignA;
    logic               inSignB;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic               inDivZero;
    logic [WIDTH-1:0]   coreLoadLo;
    logic [WIDTH-1:0]   coreLoadOperand;
    iterMode_t          iterMode;
    logic [2*WIDTH-1:0] acc;

    logic [2*WIDTH-1:0] prodSigned;
    logic [WIDTH-1:0]   quoSigned;
    logic [WIDTH-1:0]   remSigned;
    logic [2*WIDTH-1:0] fixupResult;

    // ---------------- input decode (only meaningful in IDLE) ----------------
    always_comb begin
        opIn      = hiloOp_t'(cHiLoOp);
        accept    = (state == S_IDLE) && OpValid && isValidOp(opIn) && !Flush;
        inSignA   = isSignedOp(opIn) && OperandA[WIDTH-1];
        inSignB   = isSignedOp(opIn) && OperandB[WIDTH-1];
        // Negating 0x80000000 gives 0x80000000, which is the correct
        // unsigned magnitude, so no special case is needed.
        absA      = inSignA ? (~OperandA + 1'b1) : OperandA;
        absB      = inSignB ? (~OperandB + 1'b1) : OperandB;
        inDivZero = isDivOp(opIn) && (OperandB == '0);
        // Multiply iterates over the multiplier (B); divide shifts the
        // dividend (A) through the lower half.
        coreLoadLo      = isDivOp(opIn) ? absA : absB;
        coreLoadOperand = isDivOp(opIn) ? absB : absA;
        iterMode        = isDivOp(opReg) ? MODE_DIV : MODE_MUL;
    end

    hilo_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .Clk         (Clk),
        .Reset       (Reset),
        .load        (accept),
        .step        (state == S_ITER),
        .mode        (iterMode),
        .loadLo      (coreLoadLo),
        .loadOperand (coreLoadOperand),
        .acc         (acc)
    );

    // ---------------- fix-up ----------------
    always_comb begin
        prodSigned = (signA ^ signB) ? (~acc + 1'b1) : acc;
        quoSigned  = (signA ^ signB) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        // Remainder follows the sign of the dividend.
        remSigned  = signA ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];

        unique case (opReg)
            HILO_MADD: fixupResult = hiLoCap + prodSigned;
            HILO_MSUB: fixupResult = hiLoCap - prodSigned;
            HILO_DIV,
            HILO_DIVU: fixupResult = divZero ? {origA, {WIDTH{1'b1}}}
                                             : {remSigned, quoSigned};
            default:   fixupResult = prodSigned;
        endcase
    end

    // ---------------- FSM next state / outputs ----------------
    always_comb begin
        nextState = state;
        Stall     = 1'b0;
        HiLoWrite = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    Stall     = 1'b1;
                    nextState = (inDivZero && ZERO_SKIP) ? S_FIXUP : S_ITER;
                end
            end
            S_ITER: begin
                Stall = 1'b1;
                if (Flush) begin
                    nextState = S_IDLE;
                end else if (count == CNT_W'(ITER_COUNT - 1)) begin
                    nextState = S_FIXUP;
                end
            end
            S_FIXUP: begin
                Stall     = 1'b1;
                nextState = Flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                // A flush landing on the write cycle squashes the write.
                HiLoWrite = !Flush;
                nextState = S_IDLE;
            end
            default: nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= S_IDLE;
            count     <= '0;
            opReg     <= HILO_NONE;
            signA     <= 1'b0;
            signB     <= 1'b0;
            divZero   <= 1'b0;
            hiLoCap   <= '0;
            origA     <= '0;
            resultReg <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                count   <= '0;
                opReg   <= opIn;
                signA   <= inSignA;
                signB   <= inSignB;
                divZero <= inDivZero;
                hiLoCap <= {Hi, Lo};
                origA   <= OperandA;
            end else if (state == S_ITER) begin
                count <= count + CNT_W'(1);
            end
            if (state == S_FIXUP) begin
                resultReg <= fixupResult;
            end
        end
    end

    assign Busy       = (state != S_IDLE);
    assign HiLoResult = (state == S_DONE) ? resultReg : '0;
    assign DbgState   = state;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
module tb_hilo_muldiv_sequencer;
    import hilo_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        OpValid;
    logic [2:0]  cHiLoOp;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Flush;
    logic        Stall;
    logic        Busy;
    logic        HiLoWrite;
    logic [63:0] HiLoResult;
    hiloState_t  DbgState;

    int errors = 0;
    int checks = 0;

    hilo_muldiv_sequencer #(
        .WIDTH(32),
        .ZERO_SKIP(1'b1)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .OpValid    (OpValid),
        .cHiLoOp    (cHiLoOp),
        .OperandA   (OperandA),
        .OperandB   (OperandB),
        .Hi         (Hi),
        .Lo         (Lo),
        .Flush      (Flush),
        .Stall      (Stall),
        .Busy       (Busy),
        .HiLoWrite  (HiLoWrite),
        .HiLoResult (HiLoResult),
        .DbgState   (DbgState)
    );

    // ---------------- clock ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- driver ----------------
    // Presents one op at a negedge (cycle 0), drops OpValid from cycle 1 and
    // scrambles the operand inputs, then samples 1ns after each negedge
    // until HiLoWrite or a 60-cycle budget runs out (writeCyc stays -1).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hiIn, input logic [31:0] loIn,
                          output int stallCnt, output int lastStall, output int writeCyc,
                          output logic [63:0] res);
        stallCnt  = 0;
        lastStall = -1;
        writeCyc  = -1;
        res       = '0;
        @(negedge Clk);
        OpValid  = 1'b1;
        cHiLoOp  = op;
        OperandA = a;
        OperandB = b;
        Hi       = hiIn;
        Lo       = loIn;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc == 1) begin
                OpValid  = 1'b0;
                OperandA = 32'hDEADBEEF;
                OperandB = 32'h0BADF00D;
                Hi       = 32'h55555555;
                Lo       = 32'hAAAAAAAA;
            end
            #1;
            if (Stall) begin
                stallCnt++;
                lastStall = cyc;
            end
            if (HiLoWrite) begin
                writeCyc = cyc;
                res      = HiLoResult;
                break;
            end
            @(negedge Clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset    = 1'b0;
        OpValid  = 1'b0;
        cHiLoOp  = 3'b000;
        OperandA = '0;
        OperandB = '0;
        Hi       = '0;
        Lo       = '0;
        Flush    = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        #1;
        checks++;
        if ({Stall, Busy, HiLoWrite} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got {Stall,Busy,HiLoWrite}=%b want 000", {Stall, Busy, HiLoWrite});
        end
        checks++;
        if (HiLoResult !== 64'h0) begin
            errors++;
            $display("FAIL reset_result: got %h want 0", HiLoResult);
        end
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic test_ignore_none();
        @(negedge Clk);
        OpValid = 1'b1;
        cHiLoOp = 3'b000;
        #1;
        checks++;
        if (Stall !== 1'b0) begin
            errors++;
            $display("FAIL none_stall: got %b want 0", Stall);
        end
        @(negedge Clk);
        cHiLoOp = 3'b111;
        #1;
        checks++;
        if ({Stall, Busy} !== 2'b00) begin
            errors++;
            $display("FAIL rsvd_stall_busy: got %b want 00", {Stall, Busy});
        end
        @(negedge Clk);
        OpValid = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL rsvd_busy_after: got %b want 0", Busy);
        end
    endtask

    task automatic test_mult();
        int sc, ls, wc;
        logic [63:0] r;
        run_op(3'b001, 32'hFFFFFFFD, 32'd5, 32'h0, 32'h0, sc, ls, wc, r);
        checks++;
        if (sc !== 34) begin
            errors++;
            $display("FAIL mult_stall_count: got %0d want 34", sc);
        end
        checks++;
        if (ls !== 33) begin
            errors++;
            $display("FAIL mult_last_stall: got %0d want 33", ls);
        end
        checks++;
        if (wc !== 34) begin
            errors++;
            $display("FAIL mult_write_cycle: got %0d want 34", wc);
        end
        checks++;
        if (r !== 64'hFFFFFFFF_FFFFFFF1) begin
            errors++;
            $display("FAIL mult_result: got %h want FFFFFFFFFFFFFFF1", r);
        end
        checks++;
        if (Stall !== 1'b0) begin
            errors++;
            $display("FAIL mult_done_stall: got %b want 0", Stall);
        end
        @(negedge Clk);
        #1;
        checks++;
        if ({Busy, HiLoWrite} !== 2'b00 || HiLoResult !== 64'h0) begin
            errors++;
            $display("FAIL mult_after_done: got busy/wr=%b res=%h want 00 / 0", {Busy, HiLoWrite}, HiLoResult);
        end
    endtask

    task automatic test_div_ops();
        int sc, ls, wc;
        logic [63:0] r;
        run_op(3'b110, 32'd100, 32'd7, 32'h0, 32'h0, sc, ls, wc, r);
        checks++;
        if (wc !== 34 || r !== {32'd2, 32'd14}) begin
            errors++;
            $display("FAIL divu_100_7: got cyc=%0d res=%h want cyc=34 res=%h", wc, r, {32'd2, 32'd14});
        end
        run_op(3'b101, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, sc, ls, wc, r);
        checks++;
        if (wc !== 34 || r !== 64'hFFFFFFFF_FFFFFFFD) begin
            errors++;
            $display("FAIL div_m7_2: got cyc=%0d res=%h want cyc=34 res=FFFFFFFFFFFFFFFD", wc, r);
        end
        run_op(3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, sc, ls, wc, r);
        checks++;
        if (r !== 64'h00000000_80000000) begin
            errors++;
            $display("FAIL div_overflow: got %h want 0000000080000000", r);
        end
        run_op(3'b101, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, sc, ls, wc, r);
        checks++;
        if (r !== {32'd1, 32'hFFFFFFFD}) begin
            errors++;
            $display("FAIL div_7_m2: got %h want 00000001FFFFFFFD", r);
        end
    endtask

    task automatic test_accumulate();
        int sc, ls, wc;
        logic [63:0] r;
        run_op(3'b011, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, sc, ls, wc, r);
        checks++;
        if (wc !== 34 || r !== 64'h00000001_00000000) begin
            errors++;
            $display("FAIL madd_carry: got cyc=%0d res=%h want cyc=34 res=0000000100000000", wc, r);
        end
        run_op(3'b100, 32'd1, 32'd1, 32'h0, 32'h0, sc, ls, wc, r);
        checks++;
        if (r !== 64'hFFFFFFFF_FFFFFFFF) begin
            errors++;
            $display("FAIL msub_wrap: got %h want FFFFFFFFFFFFFFFF", r);
        end
        // MULTU must not sign-extend: 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
        run_op(3'b010, 32'hFFFFFFFF, 32'd2, 32'h0, 32'h0, sc, ls, wc, r);
        checks++;
        if (r !== 64'h00000001_FFFFFFFE) begin
            errors++;
            $display("FAIL multu_big: got %h want 00000001FFFFFFFE", r);
        end
    endtask

    task automatic test_div_zero();
        int sc, ls, wc;
        logic [63:0] r;
        run_op(3'b101, 32'h12345678, 32'd0, 32'h0, 32'h0, sc, ls, wc, r);
        checks++;
        if (sc !== 2 || ls !== 1) begin
            errors++;
            $display("FAIL divzero_stall: got count=%0d last=%0d want 2 / 1", sc, ls);
        end
        checks++;
        if (wc !== 2) begin
            errors++;
            $display("FAIL divzero_write_cycle: got %0d want 2", wc);
        end
        checks++;
        if (r !== 64'h12345678_FFFFFFFF) begin
            errors++;
            $display("FAIL divzero_result: got %h want 12345678FFFFFFFF", r);
        end
    endtask

    task automatic test_flush();
        int sc, ls, wc, writes;
        logic [63:0] r;
        @(negedge Clk);
        OpValid  = 1'b1;
        cHiLoOp  = 3'b010;
        OperandA = 32'd5;
        OperandB = 32'd6;
        for (int cyc = 0; cyc <= 10; cyc++) begin
            if (cyc == 1) OpValid = 1'b0;
            if (cyc == 10) Flush = 1'b1;
            #1;
            @(negedge Clk);
        end
        Flush = 1'b0;
        #1;
        checks++;
        if ({Stall, Busy} !== 2'b00) begin
            errors++;
            $display("FAIL flush_abort: got {Stall,Busy}=%b want 00", {Stall, Busy});
        end
        writes = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge Clk);
            #1;
            if (HiLoWrite) writes++;
        end
        checks++;
        if (writes !== 0) begin
            errors++;
            $display("FAIL flush_no_write: got %0d writes want 0", writes);
        end
        run_op(3'b010, 32'd3, 32'd4, 32'h0, 32'h0, sc, ls, wc, r);
        checks++;
        if (wc !== 34 || r !== 64'd12) begin
            errors++;
            $display("FAIL flush_next_op: got cyc=%0d res=%h want cyc=34 res=%h", wc, r, 64'd12);
        end
        // Flush in IDLE blocks acceptance
        @(negedge Clk);
        OpValid = 1'b1;
        cHiLoOp = 3'b001;
        Flush   = 1'b1;
        #1;
        checks++;
        if (Stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_stall: got %b want 0", Stall);
        end
        @(negedge Clk);
        OpValid = 1'b0;
        Flush   = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_busy: got %b want 0", Busy);
        end
    endtask

    task automatic test_reset_mid();
        int sc, ls, wc;
        logic [63:0] r;
        @(negedge Clk);
        OpValid  = 1'b1;
        cHiLoOp  = 3'b110;
        OperandA = 32'd100;
        OperandB = 32'd7;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc == 1) OpValid = 1'b0;
            #1;
            @(negedge Clk);
        end
        #1;
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_precond: got busy=%b want 1", Busy);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if ({Stall, Busy, HiLoWrite} !== 3'b000 || HiLoResult !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got ctrl=%b res=%h want 000 / 0", {Stall, Busy, HiLoWrite}, HiLoResult);
        end
        @(negedge Clk);
        Reset = 1'b1;
        run_op(3'b110, 32'd100, 32'd7, 32'h0, 32'h0, sc, ls, wc, r);
        checks++;
        if (sc !== 34 || wc !== 34) begin
            errors++;
            $display("FAIL reset_mid_relatency: got stall=%0d cyc=%0d want 34 / 34", sc, wc);
        end
        checks++;
        if (r !== {32'd2, 32'd14}) begin
            errors++;
            $display("FAIL reset_mid_result: got %h want %h", r, {32'd2, 32'd14});
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_ignore_none();
        test_mult();
        test_div_ops();
        test_accumulate();
        test_div_zero();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_sequencer.md
Name: hilo_muldiv_sequencer

Overview:
- Multi-cycle controller for the EX-stage Hi/Lo unit.
- Accepts a Hi/Lo operation from ID/EX and runs an iterative 32-step multiply or divide.
- Holds the front pipeline via Stall while the operation runs, then issues a single HiLoWrite with the 64-bit {Hi,Lo} result.
- Sits beside the EX ALU. Its result feeds the EX/MEM register's Hi/Lo result and write fields in place of the single-cycle path.

Parameters:
- WIDTH, 32, operand width; only 32 supported, result is 2*WIDTH.
- ZERO_SKIP, 1, when 1 a divide-by-zero bypasses the iteration phase.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- OpValid  in  1  ID/EX holds a valid instruction this cycle.
- cHiLoOp  in  3  000 none, 001 MULT, 010 MULTU, 011 MADD, 100 MSUB, 101 DIV, 110 DIVU, 111 reserved (treated as none).
- OperandA  in  32  rs value (multiplicand / dividend).
- OperandB  in  32  rt value (multiplier / divisor).
- Hi  in  32  current Hi register.
- Lo  in  32  current Lo register.
- Flush  in  1  pipeline flush; aborts any operation in progress.
- Stall  out  1  freeze PC, IF/ID and ID/EX.
- Busy  out  1  FSM not in IDLE.
- HiLoWrite  out  1  one-cycle write strobe for {Hi,Lo}.
- HiLoResult  out  64  {Hi,Lo} result; valid only while HiLoWrite=1.

Behaviour:
- Reset (async, Reset=0): FSM=IDLE, counter=0, all internal registers=0. Outputs: Stall=0, Busy=0, HiLoWrite=0, HiLoResult=0.
- States and transitions:
  - IDLE: accept when OpValid & op in {001..110} & !Flush. Stall=1 combinationally in the accept cycle. Capture operands as absolute values plus sign flags. Capture {Hi,Lo} for MADD/MSUB. Go to ITER with count=0.
  - IDLE with op=DIV/DIVU & OperandB=0 & ZERO_SKIP: go directly to FIXUP.
  - ITER: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. count increments from 0 to 31; at 31 go to FIXUP. Stall=1.
  - FIXUP (1 cycle):
    - MULT/MADD/MSUB: negate the 64-bit product if signA^signB.
    - MADD: add captured {Hi,Lo}. MSUB: subtract the product from captured {Hi,Lo}. Both are 64-bit, wrap modulo 2^64.
    - DIV: quotient takes sign signA^signB; remainder takes sign of dividend.
    - Divide-by-zero: Lo=32'hFFFFFFFF, Hi=OperandA as captured.
    - Stall=1. Go to DONE.
  - DONE: HiLoWrite=1, HiLoResult registered {Hi,Lo}, Stall=0, return to IDLE. A new op is not accepted in DONE; the stalled instruction advances and the next op is accepted in IDLE.
- Latency:
  - Normal op accepted at cycle 0: Stall high cycles 0..33 (34 cycles), HiLoWrite at cycle 34.
  - Divide-by-zero with ZERO_SKIP: Stall high cycles 0..1, HiLoWrite at cycle 2.
- Unsigned ops: sign flags forced to 0. Signed DIV of 0x80000000 by 0xFFFFFFFF yields Lo=0x80000000, Hi=0.
- Flush in any non-IDLE state: next state IDLE, no HiLoWrite, Stall=0 from the following cycle. Flush in IDLE blocks acceptance.
- Reset asserted mid-operation: immediate abort, all outputs 0, no write.
- OpValid with op=000/111: ignored, Stall stays 0.
- Busy = (state != IDLE).
- Operand and op inputs are ignored while Busy.

Decomposition:
- Shared package hilo_pkg:
  - op encodings (HILO_NONE, HILO_MULT, HILO_MULTU, HILO_MADD, HILO_MSUB, HILO_DIV, HILO_DIVU);
  - state encodings (S_IDLE, S_ITER, S_FIXUP, S_DONE);
  - ITER_COUNT=32.
- Sub-module hilo_iter_core: the per-step datapath (64-bit accumulator/remainder register, shift-add and restoring-subtract). It has step and mode inputs and no FSM.
- FSM, counter, sign handling and FIXUP remain in hilo_muldiv_sequencer.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=5 -> Stall high 34 cycles, HiLoWrite at cycle 34, HiLoResult=0xFFFFFFFF_FFFFFFF1.
- DIVU A=100, B=7 -> HiLoResult Hi=2, Lo=14 at cycle 34. DIV A=-7, B=2 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFD.
- MADD with Hi=0, Lo=0xFFFFFFFF, A=1, B=1 -> Hi=1, Lo=0. MSUB with Hi=0, Lo=0, A=1, B=1 -> 0xFFFFFFFF_FFFFFFFF.
- DIV A=0x12345678, B=0 (ZERO_SKIP=1) -> Stall cycles 0..1, HiLoWrite at cycle 2, Hi=0x12345678, Lo=0xFFFFFFFF.
- MULTU accepted, Flush pulsed at cycle 10 -> Stall=0 and Busy=0 from cycle 11, no HiLoWrite ever. Next MULTU 3*4 completes normally with Lo=12.
- Reset driven low at cycle 20 of a DIVU -> outputs 0 immediately. After release, IDLE accepts a new op with full 34-cycle latency.
